// File: rtl/mc_control.sv
// Multi-cycle main control unit: Moore FSM sequencing the shared datapath,
// plus a retired-instruction counter and halt flag for benches.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTEXE   = 4'd6;
  localparam logic [3:0] S_RTWB    = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDIEXE = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_RTEXE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXE;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTEXE:   state_d = S_RTWB;
      S_ADDIEXE: state_d = S_ADDIWB;
      S_HALT:    state_d = S_HALT;
      // Completing states and the unused encodings all fall back to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_RTEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_RTWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Wraps freely; a reset mid-instruction discards the partial instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                retired <= '0;
    else if (ctrl.instr_done) retired <= retired + CNT_W'(1);
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign halted        = ctrl.halted;
  assign state         = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: directed and random instruction streams against a
// path/latency model of each instruction class, using a 4-bit counter build.
module tb_mc_control;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic instr_done, halted;
  logic [CNT_W-1:0] retired;

  int tests = 0;
  int fails = 0;
  int model_ret = 0;

  logic [5:0] valid_ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                                6'b001000, 6'b000100, 6'b000010};

  mc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [15:0] obs_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                          alu_src_b, alu_op, pc_source};

  // Control table for each state, taken from the per-state output listing.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      4'd0:        begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      4'd1:        asb = 2'b11;
      4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
      4'd3:        begin mr = 1; iod = 1; end
      4'd4:        begin rw = 1; m2r = 1; end
      4'd5:        begin mw = 1; iod = 1; end
      4'd6:        begin asa = 1; aop = 2'b10; end
      4'd7:        begin rw = 1; rd = 1; end
      4'd8:        begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9:        begin pw = 1; psrc = 2'b10; end
      4'd11:       rw = 1;
      default:     ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves the same way.
  // abort_at >= 0 fires an asynchronous reset during that step of the path.
  task automatic run_instr(input logic [5:0] op, input int abort_at);
    logic [3:0] path[$];
    bit halt;
    bit is_mem;
    halt = 0;
    is_mem = (op == 6'b100011) || (op == 6'b101011);
    case (op)
      6'b100011: path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: path = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000: path = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b001000: path = '{4'd0, 4'd1, 4'd10, 4'd11};
      6'b000100: path = '{4'd0, 4'd1, 4'd8};
      6'b000010: path = '{4'd0, 4'd1, 4'd9};
      default: begin
        path = '{4'd0, 4'd1};
        repeat (20) path.push_back(4'd12);
        halt = 1;
      end
    endcase
    for (int i = 0; i < path.size(); i++) begin
      check("state", state, path[i]);
      check("ctrl", obs_ctrl, exp_ctrl(path[i]));
      check("instr_done", instr_done, (!halt && i == path.size() - 1));
      check("halted", halted, (halt && i >= 2));
      check("retired", retired, model_ret);
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1;
        model_ret = 0;
        check("abort_state", state, 0);
        check("abort_retired", retired, 0);
        check("abort_done", instr_done, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      // Opcode only matters on the edges leaving DECODE and MEMADR.
      if (i == 1 || (i == 2 && is_mem)) opcode = op;
      else opcode = 6'($urandom_range(0, 63));
      @(negedge clk);
    end
    if (!halt) model_ret = (model_ret + 1) % (1 << CNT_W);
  endtask

  initial begin
    #2;
    check("rst_async_state", state, 0);
    check("rst_async_retired", retired, 0);
    check("rst_ctrl_fetch", obs_ctrl, exp_ctrl(4'd0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_done", instr_done, 0);
    @(negedge clk);
    check("first_edge_state", state, 1);
    // Put the DUT back into FETCH through a reset pulse.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    run_instr(6'b100011, -1);
    check("lw_retired", retired, 1);
    run_instr(6'b101011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b001000, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000010, -1);
    check("six_retired", retired, 6);

    // Asynchronous reset while in MEMRD (step 3 of lw).
    run_instr(6'b100011, 3);
    check("post_abort_state", state, 0);
    check("post_abort_retired", retired, 0);

    // Counter wrap on the 4-bit build.
    repeat (15) run_instr(valid_ops[$urandom_range(0, 5)], -1);
    check("pre_wrap", retired, 15);
    run_instr(6'b000010, -1);
    check("wrap", retired, 0);

    repeat (30) run_instr(valid_ops[$urandom_range(0, 5)], -1);

    // Illegal opcodes halt until reset.
    run_instr(6'b111111, -1);
    check("halt_hold", halted, 1);
    #2 reset = 1'b1;
    #1;
    check("halt_reset_state", state, 0);
    check("halt_reset_halted", halted, 0);
    @(negedge clk);
    reset = 1'b0;
    model_ret = 0;
    run_instr(6'b000001, -1);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'b000100, -1);
    check("recover_retired", retired, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
